// File: rtl/usrt_serializer_p.sv
// USRT transmit path: baud divider, 1-deep holding buffer with valid/ready,
// and a start/data/parity/stop frame FSM driving Rx on each uClk tick.
module usrt_serializer_p #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 80,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              pClk,
  input  logic              uRst,
  input  logic              en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              uClk,
  output logic              Rx,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_shift;
  logic [IDX_W-1:0]    r_idx;
  logic [1:0]          r_stop_cnt;
  logic                r_par;
  logic                r_rx;
  logic                r_frame_done;

  logic                w_tick;
  logic                w_accept;

  assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_accept   = tx_valid & ~r_hold_full & en;

  assign uClk       = w_tick;
  assign tx_ready   = ~r_hold_full;
  assign Rx         = r_rx;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

  always_ff @(posedge pClk or posedge uRst) begin
    if (uRst) begin
      r_div <= '0;
    end else if (!en || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge pClk or posedge uRst) begin
    if (uRst) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_idx        <= '0;
      r_stop_cnt   <= '0;
      r_par        <= 1'b0;
      r_rx         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // accept and load are exclusive: accept needs hold empty, load needs it full
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
      if (!en) begin
        r_state <= S_IDLE;
        r_rx    <= 1'b0;
      end else if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            if (r_hold_full) begin
              r_rx        <= 1'b1;
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
              r_par       <= (PARITY_ODD != 0);
              r_state     <= S_START;
            end else begin
              r_rx <= 1'b0;
            end
          end
          S_START: begin
            r_rx    <= r_shift[0];
            r_par   <= r_par ^ r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_W-1:1]};
            r_idx   <= IDX_W'(1);
            r_state <= S_DATA;
          end
          S_DATA: begin
            if (r_idx < IDX_W'(DATA_W)) begin
              r_rx    <= r_shift[0];
              r_par   <= r_par ^ r_shift[0];
              r_shift <= {1'b0, r_shift[DATA_W-1:1]};
              r_idx   <= r_idx + IDX_W'(1);
            end else if (PARITY_EN != 0) begin
              r_rx    <= r_par;
              r_state <= S_PARITY;
            end else begin
              r_rx       <= 1'b0;
              r_stop_cnt <= 2'd1;
              r_state    <= S_STOP;
            end
          end
          S_PARITY: begin
            r_rx       <= 1'b0;
            r_stop_cnt <= 2'd1;
            r_state    <= S_STOP;
          end
          S_STOP: begin
            if (r_stop_cnt == 2'(STOP_BITS)) begin
              r_frame_done <= 1'b1;
              if (r_hold_full) begin
                r_rx        <= 1'b1;
                r_shift     <= r_hold;
                r_hold_full <= 1'b0;
                r_par       <= (PARITY_ODD != 0);
                r_state     <= S_START;
              end else begin
                r_rx    <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_rx       <= 1'b0;
              r_stop_cnt <= r_stop_cnt + 2'd1;
            end
          end
          default: begin
            r_rx    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usrt_serializer_p.sv
// Bench for usrt_serializer_p: three parameter sets share one stimulus stream,
// each checked every cycle against a frame-queue reference model.
`timescale 1ns/1ps
module tb_usrt_serializer_p;

  localparam int NI = 3;
  localparam int DW [NI] = '{8, 8, 5};
  localparam int CD [NI] = '{4, 4, 3};
  localparam int PE [NI] = '{1, 1, 0};
  localparam int PO [NI] = '{0, 1, 0};
  localparam int SB [NI] = '{1, 2, 2};

  logic        pclk = 1'b0;
  logic        urst = 1'b0;
  logic        en = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_ready [NI];
  logic        uclk [NI];
  logic        rx [NI];
  logic        busy [NI];
  logic        done [NI];

  usrt_serializer_p #(.DATA_W(DW[0]), .CLK_DIV(CD[0]), .PARITY_EN(PE[0]), .PARITY_ODD(PO[0]), .STOP_BITS(SB[0])) u_a (
    .pClk(pclk), .uRst(urst), .en(en), .tx_data(tx_data[7:0]), .tx_valid(tx_valid),
    .tx_ready(tx_ready[0]), .uClk(uclk[0]), .Rx(rx[0]), .busy(busy[0]), .frame_done(done[0]));
  usrt_serializer_p #(.DATA_W(DW[1]), .CLK_DIV(CD[1]), .PARITY_EN(PE[1]), .PARITY_ODD(PO[1]), .STOP_BITS(SB[1])) u_b (
    .pClk(pclk), .uRst(urst), .en(en), .tx_data(tx_data[7:0]), .tx_valid(tx_valid),
    .tx_ready(tx_ready[1]), .uClk(uclk[1]), .Rx(rx[1]), .busy(busy[1]), .frame_done(done[1]));
  usrt_serializer_p #(.DATA_W(DW[2]), .CLK_DIV(CD[2]), .PARITY_EN(PE[2]), .PARITY_ODD(PO[2]), .STOP_BITS(SB[2])) u_c (
    .pClk(pclk), .uRst(urst), .en(en), .tx_data(tx_data[4:0]), .tx_valid(tx_valid),
    .tx_ready(tx_ready[2]), .uClk(uclk[2]), .Rx(rx[2]), .busy(busy[2]), .frame_done(done[2]));

  always #5 pclk = ~pclk;

  // reference model: divider count, hold slot, and the frame as a bit queue
  int          m_div [NI];
  bit          m_busy [NI];
  bit          m_rx [NI];
  bit          m_done [NI];
  bit          m_hf [NI];
  bit          m_tick [NI];
  logic [15:0] m_hold [NI];
  logic [31:0] m_sh [NI];
  int          m_rem [NI];

  int          n_tests = 0;
  int          n_fail = 0;

  bit          cap_on = 1'b0;
  logic [31:0] cap [NI];
  int          cap_n [NI];
  int          busy_cnt [NI];
  int          done_cnt [NI];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] frame_bits(input int i, input logic [15:0] w, output int len);
    logic [31:0] f;
    int pos;
    f = 32'd1;
    for (int b = 0; b < DW[i]; b++) f[1 + b] = w[b];
    pos = 1 + DW[i];
    if (PE[i] != 0) begin
      f[pos] = (^w) ^ (PO[i] != 0);
      pos++;
    end
    len = pos + SB[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_div[i] = 0; m_busy[i] = 0; m_rx[i] = 0; m_done[i] = 0;
      m_hf[i] = 0; m_tick[i] = 0; m_rem[i] = 0; m_sh[i] = '0; m_hold[i] = '0;
    end
  endtask

  task automatic model_update();
    if (urst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit hf_old;
        int len;
        logic [15:0] mask;
        mask = 16'((32'd1 << DW[i]) - 1);
        m_tick[i] = 0;
        m_done[i] = 0;
        hf_old = m_hf[i];
        if (!en) begin
          m_div[i] = 0; m_busy[i] = 0; m_rem[i] = 0; m_rx[i] = 0;
        end else begin
          if (m_div[i] == CD[i] - 1) begin
            m_tick[i] = 1;
            if (m_busy[i] && m_rem[i] > 0) begin
              m_rx[i] = m_sh[i][0];
              m_sh[i] = m_sh[i] >> 1;
              m_rem[i]--;
            end else begin
              if (m_busy[i]) m_done[i] = 1;
              if (hf_old) begin
                m_sh[i] = frame_bits(i, m_hold[i], len);
                m_rx[i] = m_sh[i][0];
                m_sh[i] = m_sh[i] >> 1;
                m_rem[i] = len - 1;
                m_busy[i] = 1;
                m_hf[i] = 0;
              end else begin
                m_busy[i] = 0;
                m_rx[i] = 0;
              end
            end
            m_div[i] = 0;
          end else begin
            m_div[i]++;
          end
          if (tx_valid && !hf_old) begin
            m_hold[i] = tx_data & mask;
            m_hf[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("rx%0d", i), 32'(rx[i]), 32'(m_rx[i]));
      check_eq($sformatf("uclk%0d", i), 32'(uclk[i]), 32'(m_div[i] == CD[i] - 1));
      check_eq($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
      check_eq($sformatf("ready%0d", i), 32'(tx_ready[i]), 32'(!m_hf[i]));
      check_eq($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
    end
  endtask

  task automatic cap_clear();
    for (int i = 0; i < NI; i++) begin
      cap[i] = '0; cap_n[i] = 0; busy_cnt[i] = 0; done_cnt[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge pclk);
    model_update();
    @(negedge pclk);
    compare_all();
    if (cap_on) begin
      for (int i = 0; i < NI; i++) begin
        if (m_tick[i] && m_busy[i]) begin
          cap[i] = {cap[i][30:0], rx[i]};
          cap_n[i]++;
        end
        if (busy[i]) busy_cnt[i]++;
        if (done[i]) done_cnt[i]++;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 400; k++) begin
      if (!m_busy[0] && !m_busy[1] && !m_busy[2] && !m_hf[0] && !m_hf[1] && !m_hf[2]) break;
      step();
    end
    check_eq(tag, {busy[0], busy[1], busy[2], tx_ready[0], tx_ready[1], tx_ready[2], rx[0], rx[1], rx[2]},
             9'b000_111_000);
  endtask

  task automatic send1(input logic [15:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    cap_clear();
    model_reset();
    #1 urst = 1'b1;
    #1 compare_all();
    step();
    step();
    urst = 1'b0;
    en = 1'b1;
    for (int j = 0; j < 6; j++) step();

    // single 0xA5 frame on all three configurations
    cap_clear();
    cap_on = 1'b1;
    send1(16'h00A5);
    wait_idle("a5_idle");
    cap_on = 1'b0;
    check_eq("a5_bits_A", cap[0], 32'b11010010100);
    check_eq("a5_len_A", cap_n[0], 11);
    check_eq("a5_bits_B", cap[1], 32'b110100101100);
    check_eq("a5_len_B", cap_n[1], 12);
    check_eq("a5_bits_C", cap[2], 32'b11010000);
    check_eq("a5_len_C", cap_n[2], 8);
    check_eq("a5_busy_A", busy_cnt[0], 44);
    check_eq("a5_busy_B", busy_cnt[1], 48);
    check_eq("a5_busy_C", busy_cnt[2], 24);
    check_eq("a5_done_A", done_cnt[0], 1);
    check_eq("a5_done_C", done_cnt[2], 1);

    // back-to-back 0x01 then 0xFF written during the first frame
    for (int j = 0; j < 5; j++) step();
    cap_clear();
    cap_on = 1'b1;
    send1(16'h0001);
    for (k = 0; k < 50; k++) begin
      if (m_busy[0] && m_busy[1] && m_busy[2] && !m_hf[0] && !m_hf[1] && !m_hf[2]) break;
      step();
    end
    check_eq("b2b_loaded", {busy[0], tx_ready[0]}, 2'b11);
    send1(16'h00FF);
    check_eq("b2b_ready_low", 32'(tx_ready[0]), 32'd0);
    wait_idle("b2b_idle");
    cap_on = 1'b0;
    check_eq("b2b_bits_A", cap[0], 32'b1100000001011111111100);
    check_eq("b2b_len_A", cap_n[0], 22);
    check_eq("b2b_done_A", done_cnt[0], 2);

    // en dropped mid-frame of 0x3C with 0x55 held, then resumed
    for (int j = 0; j < 3; j++) step();
    tx_data = 16'h003C;
    tx_valid = 1'b1;
    step();
    tx_data = 16'h0055;
    for (k = 0; k < 50; k++) begin
      if (m_hf[0] && m_hf[1] && m_hf[2] && m_busy[0]) break;
      step();
    end
    tx_valid = 1'b0;
    check_eq("abort_held", 32'(tx_ready[0]), 32'd0);
    for (k = 0; k < 60; k++) begin
      if (m_busy[0] && m_rem[0] == 6) break;
      step();
    end
    check_eq("abort_bit3", 32'(rx[0]), 32'd1);
    en = 1'b0;
    cap_clear();
    cap_on = 1'b1;
    for (int j = 0; j < 6; j++) step();
    check_eq("abort_done", done_cnt[0] + done_cnt[1], 0);
    check_eq("abort_busy", busy_cnt[0] + busy_cnt[1], 0);
    check_eq("abort_rx", {rx[0], rx[1], rx[2], uclk[0]}, 4'b0000);
    cap_clear();
    en = 1'b1;
    wait_idle("resume_idle");
    cap_on = 1'b0;
    check_eq("resume_bits_A", cap[0], 32'b11010101000);
    check_eq("resume_bits_B", cap[1], 32'b110101010100);
    check_eq("resume_done_A", done_cnt[0], 1);

    // asynchronous reset away from a clock edge, mid-frame
    send1(16'h0096);
    for (int j = 0; j < 14; j++) step();
    check_eq("pre_rst_busy", 32'(busy[0]), 32'd1);
    #2 urst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_async", {rx[0], uclk[0], busy[0], tx_ready[0], done[0], rx[1], busy[1], rx[2], busy[2]},
             9'b000100000);
    compare_all();
    step();
    step();
    urst = 1'b0;
    for (k = 1; k < 10; k++) begin
      step();
      if (uclk[0]) break;
    end
    check_eq("rst_first_tick", k, 3);
    wait_idle("rst_idle");

    // randomized traffic with changing data, en drops and rare resets
    for (int j = 0; j < 3000; j++) begin
      tx_valid = ($urandom_range(0, 99) < 60);
      tx_data = 16'($urandom);
      if (!en) en = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 199) == 0) en = 1'b0;
      urst = ($urandom_range(0, 999) == 0);
      step();
    end
    urst = 1'b0;
    en = 1'b1;
    tx_valid = 1'b0;
    wait_idle("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
